// File: rtl/line_buffer_ctrl.sv
// rtl/line_buffer_ctrl.sv - raster line buffer that emits ROWS-tall window columns
// Optional macro LINE_BUFFER_CFG_ERR_EN adds a sticky err output for an illegal row_width.
module line_buffer_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int ROWS          = 3,
    parameter int MAX_ROW_WIDTH = 1024,
    parameter int ADDR_WIDTH    = $clog2(MAX_ROW_WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [ADDR_WIDTH:0]        row_width,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [DATA_WIDTH-1:0]      s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [ROWS*DATA_WIDTH-1:0] m_data,
    output logic                       m_last,
    output logic [$clog2(ROWS+2)-1:0]  rows_full
`ifdef LINE_BUFFER_CFG_ERR_EN
    ,
    output logic                       err
`endif
);
    localparam int NB     = ROWS + 1;
    localparam int BANK_W = $clog2(NB);
    localparam int RF_W   = $clog2(ROWS + 2);
    localparam logic [ADDR_WIDTH:0] MAX_RW    = (ADDR_WIDTH+1)'(MAX_ROW_WIDTH);
    localparam logic [RF_W-1:0]     ROWS_RF   = RF_W'(ROWS);
    localparam logic [RF_W-1:0]     NB_RF     = RF_W'(NB);
    localparam logic [BANK_W-1:0]   LAST_BANK = BANK_W'(NB - 1);
    localparam logic [BANK_W:0]     NB_EXT    = (BANK_W+1)'(NB);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
    state_t state, state_nxt;

    logic [ADDR_WIDTH:0]        rw_eff;
    logic [ADDR_WIDTH-1:0]      last_col;
    logic [ADDR_WIDTH-1:0]      wr_col, rd_col, rd_col_nxt;
    logic [BANK_W-1:0]          wr_bank, rd_base, sel_base;
    logic [RF_W-1:0]            rows_full_q, rows_full_nxt;
    logic                       ready_q, err_nxt, cfg_bad;
    logic                       wr_fire, row_done, release_row, pop;
    logic                       rd_issue, rd_vld, rd_last_q, space, streaming;
    logic [1:0]                 occ, fifo_cnt, fifo_last;
    logic [DATA_WIDTH-1:0]      bank_q [NB];
    logic [ROWS*DATA_WIDTH-1:0] push_data;
    logic [ROWS*DATA_WIDTH-1:0] fifo_data [2];

    always_comb begin
        rw_eff = row_width;
        if (row_width == '0) begin
            rw_eff = (ADDR_WIDTH+1)'(1);
        end else if (row_width > MAX_RW) begin
            rw_eff = MAX_RW;
        end
    end
    assign last_col = ADDR_WIDTH'(rw_eff - 1'b1);

`ifdef LINE_BUFFER_CFG_ERR_EN
    logic err_q;
    assign cfg_bad = (row_width == '0) || (row_width > MAX_RW);
    assign err_nxt = err_q || (s_valid && (wr_col == '0) && cfg_bad);
    assign err     = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_nxt;
        end
    end
`else
    assign cfg_bad = 1'b0;
    assign err_nxt = 1'b0;
`endif

    // A pixel arriving at column 0 with an illegal width is dropped, never stored.
    assign wr_fire       = s_valid && ready_q && !(cfg_bad && (wr_col == '0));
    assign row_done      = wr_fire && (wr_col == last_col);
    assign pop           = m_valid && m_ready;
    assign release_row   = pop && fifo_last[0];
    assign rows_full_nxt = rows_full_q + RF_W'(row_done) - RF_W'(release_row);

    // In-flight reads count against the 2-entry skid so it can never overflow.
    assign occ       = fifo_cnt + {1'b0, rd_vld};
    assign space     = (occ < 2'd2) || pop;
    assign streaming = (state == STREAM) || ((state == IDLE) && (rows_full_q >= ROWS_RF));

    always_comb begin
        state_nxt  = state;
        rd_col_nxt = rd_col;
        rd_issue   = 1'b0;
        unique case (state)
            IDLE, STREAM: begin
                if (streaming) begin
                    state_nxt = STREAM;
                    if (space) begin
                        rd_issue = 1'b1;
                        if (rd_col == last_col) begin
                            state_nxt  = DRAIN;
                            rd_col_nxt = '0;
                        end else begin
                            rd_col_nxt = rd_col + 1'b1;
                        end
                    end
                end
            end
            DRAIN: begin
                if (release_row) begin
                    state_nxt = (rows_full_nxt >= ROWS_RF) ? STREAM : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state       <= IDLE;
            wr_col      <= '0;
            wr_bank     <= '0;
            rd_col      <= '0;
            rd_base     <= '0;
            sel_base    <= '0;
            rows_full_q <= '0;
            rd_vld      <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            rd_col      <= rd_col_nxt;
            rows_full_q <= rows_full_nxt;
            rd_vld      <= rd_issue;
            if (rd_issue) begin
                sel_base  <= rd_base;
                rd_last_q <= (rd_col == last_col);
            end
            if (wr_fire) begin
                if (row_done) begin
                    wr_col  <= '0;
                    wr_bank <= (wr_bank == LAST_BANK) ? '0 : wr_bank + 1'b1;
                end else begin
                    wr_col <= wr_col + 1'b1;
                end
            end
            if (release_row) begin
                rd_base <= (rd_base == LAST_BANK) ? '0 : rd_base + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b0;
        end else if (flush) begin
            ready_q <= !err_nxt;
        end else begin
            ready_q <= (rows_full_nxt < NB_RF) && !err_nxt;
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [MAX_ROW_WIDTH];
        logic [DATA_WIDTH-1:0] q;
        always_ff @(posedge clk) begin
            if (wr_fire && !rst && !flush && (wr_bank == BANK_W'(b))) begin
                mem[wr_col] <= s_data;
            end
            if (rd_issue) begin
                q <= mem[rd_col];
            end
        end
        assign bank_q[b] = q;
    end

    // Slice i comes from bank (base + i) mod NB, so slice 0 is always the oldest row.
    for (genvar i = 0; i < ROWS; i++) begin : g_col
        logic [BANK_W:0]   sum;
        logic [BANK_W-1:0] idx;
        assign sum = {1'b0, sel_base} + (BANK_W+1)'(i);
        assign idx = (sum >= NB_EXT) ? BANK_W'(sum - NB_EXT) : sum[BANK_W-1:0];
        assign push_data[i*DATA_WIDTH +: DATA_WIDTH] = bank_q[idx];
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            fifo_cnt     <= '0;
            fifo_last    <= '0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
        end else begin
            unique case ({rd_vld, pop})
                2'b10: begin
                    if (fifo_cnt == 2'd0) begin
                        fifo_data[0] <= push_data;
                        fifo_last[0] <= rd_last_q;
                    end else begin
                        fifo_data[1] <= push_data;
                        fifo_last[1] <= rd_last_q;
                    end
                    fifo_cnt <= fifo_cnt + 1'b1;
                end
                2'b01: begin
                    fifo_data[0] <= fifo_data[1];
                    fifo_last[0] <= fifo_last[1];
                    fifo_cnt     <= fifo_cnt - 1'b1;
                end
                2'b11: begin
                    if (fifo_cnt == 2'd1) begin
                        fifo_data[0] <= push_data;
                        fifo_last[0] <= rd_last_q;
                    end else begin
                        fifo_data[0] <= fifo_data[1];
                        fifo_last[0] <= fifo_last[1];
                        fifo_data[1] <= push_data;
                        fifo_last[1] <= rd_last_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_valid   = (fifo_cnt != 2'd0);
    assign m_data    = m_valid ? fifo_data[0] : '0;
    assign m_last    = m_valid && fifo_last[0];
    assign rows_full = rows_full_q;
    assign s_ready   = ready_q;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// tb/tb_line_buffer_ctrl.sv - randomized self-checking bench for line_buffer_ctrl
module tb_line_buffer_ctrl;
    localparam int DW   = 32;
    localparam int ROWS = 3;
    localparam int MAXW = 1024;
    localparam int AW   = $clog2(MAXW);
    localparam int RFW  = $clog2(ROWS + 2);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 flush = 1'b0;
    logic [AW:0]          row_width = (AW+1)'(4);
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic [DW-1:0]        s_data = '0;
    logic                 m_valid;
    logic                 m_ready = 1'b0;
    logic [ROWS*DW-1:0]   m_data;
    logic                 m_last;
    logic [RFW-1:0]       rows_full;
`ifdef LINE_BUFFER_CFG_ERR_EN
    logic                 err;
`endif

    line_buffer_ctrl #(
        .DATA_WIDTH(DW), .ROWS(ROWS), .MAX_ROW_WIDTH(MAXW)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .row_width(row_width),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .rows_full(rows_full)
`ifdef LINE_BUFFER_CFG_ERR_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rw = 4;
    int col_k = 0;
    logic [31:0] rowmem[$];
    logic [31:0] part[$];
    bit prev_stall = 1'b0;
    bit prev_flush = 1'b0;
    bit acc;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        rowmem.delete();
        part.delete();
        col_k = 0;
        prev_stall = 1'b0;
        prev_flush = 1'b0;
    endfunction

    // One clock: drive inputs, compare against the row model, advance the model on the edge.
    task automatic cycle(input bit sv, input logic [31:0] sd, input bit mr, input bit fl, output bit accepted);
        bit in_hs, out_hs;
        int nrows;
        logic [ROWS*DW-1:0] exp_col;
        s_valid = sv; s_data = sd; m_ready = mr; flush = fl;
        #1;
        nrows = rowmem.size() / rw;
        check("rows_full", 128'(rows_full), 128'(nrows));
        check("s_ready", 128'(s_ready), 128'(nrows < ROWS + 1));
        if (prev_stall) check("stall_hold", 128'(m_valid), 128'(1));
        if (prev_flush) check("flush_mvalid", 128'(m_valid), 128'(0));
        if (m_valid) begin
            if (nrows < ROWS) begin
                check("spurious_valid", 128'(m_valid), 128'(0));
            end else begin
                for (int i = 0; i < ROWS; i++) exp_col[i*DW +: DW] = rowmem[i*rw + col_k];
                check("m_data", 128'(m_data), 128'(exp_col));
                check("m_last", 128'(m_last), 128'(col_k == rw - 1));
            end
        end
        in_hs      = sv && s_ready && !fl;
        out_hs     = m_valid && mr && !fl && (nrows >= ROWS);
        prev_stall = m_valid && !mr && !fl;
        prev_flush = fl;
        accepted   = in_hs;
        @(posedge clk);
        cyc++;
        if (fl) begin
            rowmem.delete(); part.delete(); col_k = 0;
        end else begin
            if (out_hs) begin
                if (col_k == rw - 1) begin
                    col_k = 0;
                    for (int i = 0; i < rw; i++) void'(rowmem.pop_front());
                end else begin
                    col_k++;
                end
            end
            if (in_hs) begin
                part.push_back(sd);
                if (part.size() == rw) begin
                    foreach (part[i]) rowmem.push_back(part[i]);
                    part.delete();
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; s_valid = 1'b0; flush = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); @(negedge clk);
            check("rst_s_ready", 128'(s_ready), 128'(0));
            check("rst_m_valid", 128'(m_valid), 128'(0));
            check("rst_m_last", 128'(m_last), 128'(0));
            check("rst_m_data", 128'(m_data), 128'(0));
            check("rst_rows_full", 128'(rows_full), 128'(0));
`ifdef LINE_BUFFER_CFG_ERR_EN
            check("rst_err", 128'(err), 128'(0));
`endif
        end
        rst = 1'b0;
        model_clear();
        @(posedge clk); @(negedge clk);
        check("post_rst_s_ready", 128'(s_ready), 128'(1));
    endtask

    task automatic feed(input int n, input int base, input int mode);
        int sent = 0;
        int tries = 0;
        bit a, mr;
        while (sent < n && tries < 400) begin
            case (mode)
                1: mr = 1'b1;
                2: mr = (cyc % 2) == 1;
                3: mr = $urandom_range(0, 1) == 1;
                default: mr = 1'b0;
            endcase
            cycle(1'b1, 32'(base + sent), mr, 1'b0, a);
            if (a) sent++;
            tries++;
        end
        check("feed_done", 128'(sent), 128'(n));
    endtask

    task automatic drain(input int n, input int mode);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, (mode == 2) ? ((cyc % 2) == 1) : 1'b1, 1'b0, acc);
        for (int i = 0; i < 40; i++) cycle(1'b0, 32'd0, 1'b1, 1'b0, acc);
        check("drain_idle", 128'(m_valid), 128'(0));
    endtask

    task automatic do_flush(input int new_rw);
        cycle(1'b0, 32'd0, 1'b1, 1'b1, acc);
        row_width = (AW+1)'(new_rw);
        rw = (new_rw == 0) ? 1 : new_rw;
    endtask

    int widths[6];

    initial begin
        do_reset(3);

        // First pass latency and content, rows_full 3 -> 2
        feed(11, 1, 1);
        cycle(1'b1, 32'd12, 1'b1, 1'b0, acc);
        check("p12_accepted", 128'(acc), 128'(1));
        check("lat_e0", 128'(m_valid), 128'(0));
        cycle(1'b0, 32'd0, 1'b1, 1'b0, acc);
        check("lat_e1", 128'(m_valid), 128'(0));
        cycle(1'b0, 32'd0, 1'b1, 1'b0, acc);
        check("lat_e2", 128'(m_valid), 128'(1));
        check("first_col", 128'(m_data), 128'({32'd9, 32'd5, 32'd1}));
        drain(4, 1);
        check("rows_after_pass", 128'(rows_full), 128'(2));

        // Back-pressure to full, then release
        do_flush(4);
        feed(16, 1, 0);
        check("full_rows", 128'(rows_full), 128'(4));
        check("full_s_ready", 128'(s_ready), 128'(0));
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 32'd17, 1'b0, 1'b0, acc);
            check("stall_p17", 128'(acc), 128'(0));
        end
        feed(4, 17, 1);
        drain(10, 1);

        // Toggling m_ready during a pass
        do_flush(4);
        feed(12, 1, 2);
        drain(30, 2);

        // Flush mid-row
        do_flush(4);
        feed(6, 1, 1);
        do_flush(4);
        check("flush_rows", 128'(rows_full), 128'(0));
        feed(12, 101, 1);
        drain(4, 1);

`ifndef LINE_BUFFER_CFG_ERR_EN
        // row_width 0 behaves as 1: every pixel is a row, every column is last
        do_flush(0);
        feed(6, 200, 1);
        drain(4, 1);
        widths = '{4, 1, 0, 2, 5, 7};
`else
        widths = '{4, 1, 3, 2, 5, 7};
`endif

        foreach (widths[w]) begin
            do_flush(widths[w]);
            if (w == 3) begin
                for (int i = 0; i < 20; i++)
                    cycle(1'b1, $urandom, $urandom_range(0, 1) == 1, 1'b0, acc);
                do_reset(2);
            end
            for (int i = 0; i < 300; i++)
                cycle($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
                      $urandom_range(0, 149) == 0, acc);
            drain(10, 1);
        end

`ifdef LINE_BUFFER_CFG_ERR_EN
        do_flush(0);
        s_valid = 1'b1; s_data = 32'd1; m_ready = 1'b1; flush = 1'b0;
        @(posedge clk); @(negedge clk);
        check("err_set", 128'(err), 128'(1));
        check("err_s_ready", 128'(s_ready), 128'(0));
        @(posedge clk); @(negedge clk);
        check("err_hold", 128'(err), 128'(1));
        flush = 1'b1;
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        check("err_after_flush", 128'(err), 128'(1));
        check("err_flush_ready", 128'(s_ready), 128'(0));
        s_valid = 1'b0;
        row_width = (AW+1)'(4);
        rw = 4;
        do_reset(1);
        check("err_cleared", 128'(err), 128'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
